// File: rtl/hdmi_vram_reader.sv
// ============================================================================
// hdmi_vram_reader: quarter-resolution VRAM fetch with 4x4 pixel replication,
// RGB332 -> RGB888 expansion and timing strobes delayed to match the data.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hdmi_vram_reader #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              de_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_re,
  input  logic [7:0]        vram_rdata,
  output logic [23:0]       rgb_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              fmt_err
);

  localparam int C_XCELLS = H_ACTIVE / 4;
  localparam int C_YCELLS = V_ACTIVE / 4;
  localparam int C_XW     = (C_XCELLS > 1) ? $clog2(C_XCELLS) : 1;
  localparam int C_YW     = (C_YCELLS > 1) ? $clog2(C_YCELLS) : 1;
  localparam logic [C_XW-1:0]   C_XMAX = C_XW'(C_XCELLS - 1);
  localparam logic [C_YW-1:0]   C_YMAX = C_YW'(C_YCELLS - 1);
  localparam logic [ADDR_W-1:0] C_ROW  = ADDR_W'(C_XCELLS);

  logic [1:0]        r_x_sub;
  logic [C_XW-1:0]   r_x_cell;
  logic [1:0]        r_y_sub;
  logic [C_YW-1:0]   r_y_cell;
  logic [ADDR_W-1:0] r_line_base;
  logic              r_de_d;
  logic              r_hs_d;
  logic              r_vs_d;

  logic w_frame_start;
  logic w_line_end;

  // First delay stage doubles as the de/vsync edge-detector history.
  assign w_frame_start = vsync_in & ~r_vs_d;
  assign w_line_end    = ~de_in & r_de_d;

  assign vram_addr = r_line_base + ADDR_W'(r_x_cell);
  assign vram_re   = de_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_sub     <= 2'd0;
      r_x_cell    <= '0;
      r_y_sub     <= 2'd0;
      r_y_cell    <= '0;
      r_line_base <= '0;
      fmt_err     <= 1'b0;
    end else if (w_frame_start) begin
      r_x_sub     <= 2'd0;
      r_x_cell    <= '0;
      r_y_sub     <= 2'd0;
      r_y_cell    <= '0;
      r_line_base <= '0;
      fmt_err     <= 1'b0;
    end else if (de_in) begin
      r_x_sub <= r_x_sub + 2'd1;
      if (r_x_sub == 2'd3) begin
        if (r_x_cell == C_XMAX) begin
          fmt_err <= 1'b1;
        end else begin
          r_x_cell <= r_x_cell + 1'b1;
        end
      end
    end else if (w_line_end) begin
      r_x_sub  <= 2'd0;
      r_x_cell <= '0;
      r_y_sub  <= r_y_sub + 2'd1;
      if (r_y_sub == 2'd3) begin
        if (r_y_cell == C_YMAX) begin
          fmt_err <= 1'b1;
        end else begin
          r_y_cell    <= r_y_cell + 1'b1;
          r_line_base <= r_line_base + C_ROW;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_de_d    <= 1'b0;
      r_hs_d    <= 1'b0;
      r_vs_d    <= 1'b0;
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      rgb_out   <= 24'h0;
    end else begin
      r_de_d    <= de_in;
      r_hs_d    <= hsync_in;
      r_vs_d    <= vsync_in;
      de_out    <= r_de_d;
      hsync_out <= r_hs_d;
      vsync_out <= r_vs_d;
      // Bit replication maps full-scale 3/2-bit fields onto full-scale 8-bit.
      if (r_de_d) begin
        rgb_out <= {vram_rdata[7:5], vram_rdata[7:5], vram_rdata[7:6],
                    vram_rdata[4:2], vram_rdata[4:2], vram_rdata[4:3],
                    {4{vram_rdata[1:0]}}};
      end else begin
        rgb_out <= 24'h0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hdmi_vram_reader.sv
// Directed bench for hdmi_vram_reader at 16x8 active resolution.
`default_nettype none

module tb_hdmi_vram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        de_in, hsync_in, vsync_in;
  logic [15:0] vram_addr;
  logic        vram_re;
  logic [7:0]  vram_rdata;
  logic [23:0] rgb_out;
  logic        de_out, hsync_out, vsync_out, fmt_err;

  logic [7:0]  mem [0:63];
  logic [23:0] exp_col [0:3];
  int          tests = 0;
  int          fails = 0;

  hdmi_vram_reader #(.H_ACTIVE(16), .V_ACTIVE(8), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .vram_addr(vram_addr), .vram_re(vram_re), .vram_rdata(vram_rdata),
    .rgb_out(rgb_out), .de_out(de_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .fmt_err(fmt_err)
  );

  always #5 clk = ~clk;

  // Block RAM model: 1-cycle read latency, garbage (FF) when not enabled.
  always @(posedge clk) vram_rdata <= vram_re ? mem[vram_addr[5:0]] : 8'hFF;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vsync();
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b1;
    cyc(); cyc();
    vsync_in = 1'b0;
    cyc();
  endtask

  task automatic run_line(input int n, input int gap);
    de_in = 1'b1;
    for (int i = 0; i < n; i++) cyc();
    de_in = 1'b0;
    for (int i = 0; i < gap; i++) cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    cyc(); cyc(); cyc();
    tests++; if (rgb_out !== 24'h0) begin fails++; $display("FAIL reset rgb_out: got %h expected 000000", rgb_out); end
    tests++; if ({de_out, hsync_out, vsync_out} !== 3'b000) begin fails++; $display("FAIL reset strobes: got %b expected 000", {de_out, hsync_out, vsync_out}); end
    tests++; if (fmt_err !== 1'b0) begin fails++; $display("FAIL reset fmt_err: got %b expected 0", fmt_err); end
    tests++; if (vram_addr !== 16'd0) begin fails++; $display("FAIL reset vram_addr: got %0d expected 0", vram_addr); end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_address();
    logic [15:0] exp_a;
    do_vsync();
    tests++; if (fmt_err !== 1'b0) begin fails++; $display("FAIL addr fmt_err after vsync: got %b expected 0", fmt_err); end
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < 16; p++) begin
        de_in = 1'b1; #1;
        exp_a = 16'((l / 4) * 4 + p / 4);
        tests++; if (vram_addr !== exp_a) begin fails++; $display("FAIL addr line%0d px%0d: got %0d expected %0d", l, p, vram_addr, exp_a); end
        tests++; if (vram_re !== 1'b1) begin fails++; $display("FAIL vram_re line%0d px%0d: got %b expected 1", l, p, vram_re); end
        cyc();
      end
      de_in = 1'b0; hsync_in = 1'b1; cyc();
      hsync_in = 1'b0; cyc(); cyc();
    end
  endtask

  task automatic test_colour();
    logic        pd, ph, pv;
    logic [23:0] prgb, crgb;
    do_vsync();
    cyc(); cyc();
    pd = 1'b0; ph = 1'b0; pv = 1'b0; prgb = 24'h0;
    for (int i = 0; i < 26; i++) begin
      de_in    = (i >= 3 && i < 19);
      hsync_in = (i == 19 || i == 20);
      vsync_in = (i < 2);
      crgb = 24'h0;
      if (de_in) crgb = exp_col[(i - 3) / 4];
      cyc();
      tests++; if ({de_out, hsync_out, vsync_out} !== {pd, ph, pv}) begin fails++; $display("FAIL colour strobes step%0d: got %b expected %b", i, {de_out, hsync_out, vsync_out}, {pd, ph, pv}); end
      tests++; if (rgb_out !== prgb) begin fails++; $display("FAIL colour rgb step%0d: got %h expected %h", i, rgb_out, prgb); end
      pd = de_in; ph = hsync_in; pv = vsync_in; prgb = crgb;
    end
  endtask

  task automatic test_blanking();
    de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      tests++; if (rgb_out !== 24'h0 || vram_rdata !== 8'hFF) begin fails++; $display("FAIL blanking step%0d: rgb %h rdata %h expected 000000 / ff", i, rgb_out, vram_rdata); end
    end
  endtask

  task automatic test_v_overrun();
    logic [15:0] exp_a;
    do_vsync();
    for (int l = 0; l < 8; l++) run_line(16, 3);
    for (int p = 0; p < 16; p++) begin
      de_in = 1'b1; #1;
      exp_a = 16'(4 + p / 4);
      tests++; if (vram_addr !== exp_a) begin fails++; $display("FAIL v_overrun line8 px%0d: got %0d expected %0d", p, vram_addr, exp_a); end
      cyc();
    end
    de_in = 1'b0; cyc();
    tests++; if (fmt_err !== 1'b1) begin fails++; $display("FAIL v_overrun fmt_err: got %b expected 1", fmt_err); end
  endtask

  task automatic test_h_overrun();
    logic [15:0] exp_a;
    do_vsync();
    tests++; if (fmt_err !== 1'b0) begin fails++; $display("FAIL h_overrun fmt_err cleared by vsync: got %b expected 0", fmt_err); end
    for (int p = 0; p < 20; p++) begin
      de_in = 1'b1; #1;
      exp_a = (p < 16) ? 16'(p / 4) : 16'd3;
      tests++; if (vram_addr !== exp_a) begin fails++; $display("FAIL h_overrun px%0d: got %0d expected %0d", p, vram_addr, exp_a); end
      cyc();
    end
    de_in = 1'b0; cyc(); cyc();
    tests++; if (fmt_err !== 1'b1) begin fails++; $display("FAIL h_overrun fmt_err: got %b expected 1", fmt_err); end
    vsync_in = 1'b1; cyc();
    tests++; if (fmt_err !== 1'b0) begin fails++; $display("FAIL h_overrun fmt_err after vsync edge: got %b expected 0", fmt_err); end
    vsync_in = 1'b0; cyc();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_a;
    do_vsync();
    for (int l = 0; l < 5; l++) begin
      de_in = 1'b1; #1;
      exp_a = (l == 4) ? 16'd4 : 16'd0;
      tests++; if (vram_addr !== exp_a) begin fails++; $display("FAIL back_to_back line%0d: got %0d expected %0d", l, vram_addr, exp_a); end
      cyc();
      de_in = 1'b0; cyc();
    end
  endtask

  task automatic test_reset_midframe();
    do_vsync();
    for (int l = 0; l < 5; l++) run_line(1, 1);
    for (int p = 0; p < 6; p++) begin
      de_in = 1'b1; #1;
      if (p == 5) begin
        tests++; if (vram_addr !== 16'd5) begin fails++; $display("FAIL midframe line5 px5: got %0d expected 5", vram_addr); end
      end
      cyc();
    end
    rst = 1'b1; cyc();
    tests++; if (rgb_out !== 24'h0 || {de_out, hsync_out, vsync_out, fmt_err} !== 4'b0000) begin fails++; $display("FAIL midframe reset outputs: rgb %h flags %b expected 000000 / 0000", rgb_out, {de_out, hsync_out, vsync_out, fmt_err}); end
    tests++; if (vram_addr !== 16'd0) begin fails++; $display("FAIL midframe reset addr: got %0d expected 0", vram_addr); end
    rst = 1'b0; de_in = 1'b0; cyc(); cyc();
    for (int p = 0; p < 6; p++) begin
      de_in = 1'b1; #1;
      tests++; if (vram_addr !== 16'(p / 4)) begin fails++; $display("FAIL midframe after reset px%0d: got %0d expected %0d", p, vram_addr, p / 4); end
      cyc();
    end
    de_in = 1'b0; cyc(); cyc();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    mem[0] = 8'hE0; mem[1] = 8'h1C; mem[2] = 8'h03; mem[3] = 8'h92;
    exp_col[0] = 24'hFF0000; exp_col[1] = 24'h00FF00;
    exp_col[2] = 24'h0000FF; exp_col[3] = 24'h9292AA;
    rst = 1'b1; de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    test_reset();
    test_address();
    test_colour();
    test_blanking();
    test_v_overrun();
    test_h_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
